// File: rtl/reg_file_sb_if.sv
// Register-file bus between decode/writeback (master) and reg_file_sb (slave).
//   we3/A3/WD3        : writeback write port
//   A1/A2 -> RD1/RD2  : combinational read ports
//   rsv_en/rsv_addr   : scoreboard reserve request from issue
//   busy1/busy2       : scoreboard bits of A1/A2
//   busy_cnt          : number of registers currently busy
interface reg_file_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            we3;
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            busy1;
  logic            busy2;
  logic [AW:0]     busy_cnt;

  modport master (
    output we3, A1, A2, A3, WD3, rsv_en, rsv_addr,
    input  RD1, RD2, busy1, busy2, busy_cnt
  );

  modport slave (
    input  we3, A1, A2, A3, WD3, rsv_en, rsv_addr,
    output RD1, RD2, busy1, busy2, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register busy scoreboard.
//   Two combinational read ports, one synchronous write port, x0 hard-wired to zero.
//   Synchronous active-high reset clears all entries, busy bits and busy_cnt.
//   Scoreboard: reserve (rsv_en) sets a busy bit, a write clears it; reserve wins on a
//   same-address collision. busy_cnt is a registered population count of the busy bits.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : reg_file_sb_if.slave (read/write/reserve signals, see interface)
// Optional feature (macro REGFILE_BYPASS_EN): write-through forwarding of WD3 onto
//   RD1/RD2 when the read address matches the write address in the same cycle.
module reg_file_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  logic wr_ok, rsv_ok, cnt_inc, cnt_dec;
  logic [XLEN-1:0] rd1, rd2;

  assign wr_ok  = bus.we3 && (bus.A3 != '0);
  assign rsv_ok = bus.rsv_en && (bus.rsv_addr != '0);

  // A reserve only counts if the register was idle; a release only counts if the
  // register was busy and is not being re-reserved in the same cycle.
  assign cnt_inc = rsv_ok && !busy_q[bus.rsv_addr];
  assign cnt_dec = wr_ok && busy_q[bus.A3] && !(rsv_ok && (bus.rsv_addr == bus.A3));

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.A3] = 1'b0;
    if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (cnt_inc && !cnt_dec)      busy_cnt_d = busy_cnt_q + CntOne;
    else if (cnt_dec && !cnt_inc) busy_cnt_d = busy_cnt_q - CntOne;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok) regs_q[bus.A3] <= bus.WD3;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rd1 = regs_q[bus.A1];
    rd2 = regs_q[bus.A2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.A1 == bus.A3)) rd1 = bus.WD3;
    if (wr_ok && (bus.A2 == bus.A3)) rd2 = bus.WD3;
`endif
    if (rst || (bus.A1 == '0)) rd1 = '0;
    if (rst || (bus.A2 == '0)) rd2 = '0;
  end

  assign bus.RD1      = rd1;
  assign bus.RD2      = rd2;
  // Busy bits as they were before the current edge; no scoreboard bypass.
  assign bus.busy1    = !rst && (bus.A1 != '0) && busy_q[bus.A1];
  assign bus.busy2    = !rst && (bus.A2 != '0) && busy_q[bus.A2];
  assign bus.busy_cnt = busy_cnt_q;
endmodule
